dual_port_ram_be: RTL and testbench

DUAL_PORT_RAM_BE -- requirements
Module: dual_port_ram_be

---
 rtl/dual_port_ram_be.sv | 240 ++++++++++++++++++++++++
 tb/tb_dual_port_ram_be.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// dual_port_ram_be
//
// Simple dual-port RAM: one write port with per-byte lane enables and one read
// port, both on clk. After reset the array can optionally be zero-filled by an
// internal clear sequence that writes one word per cycle.
//
// Parameters
//   ADDR_WIDTH     word address width, depth = 2**ADDR_WIDTH
//   DATA_WIDTH     word width, multiple of 8
//   RDW_MODE       same-address read-during-write: 0 = old word, 1 = merged word
//   OUT_REG        1 adds one output pipeline stage (read latency +1)
//   CLEAR_ON_RESET 1 zero-fills the array after every reset
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   waddr       write word address
//   raddr       read word address
//   din         write data
//   byte_en     write lane enables, bit i covers din[8i+7:8i]
//   write_en    write request
//   read_en     read request
//   dout        registered read data, held until the next completed read
//   dout_valid  one-cycle strobe marking new dout
//   init_busy   high while the clear sequence runs (requests ignored)
//
// Handshake: there is no backpressure. A request is accepted on any rising
// edge where it is asserted and init_busy is low; every accepted read produces
// exactly one dout_valid strobe a fixed number of edges later, so reads may be
// issued every cycle.
//
// FSM visibility: the two-state controller is fully observable on init_busy,
// which is a registered copy of (state == ST_CLEAR).
// -----------------------------------------------------------------------------
module dual_port_ram_be #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    write_en,
  input  logic                    read_en,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    init_busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
      $error("dual_port_ram_be: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
      $error("dual_port_ram_be: ADDR_WIDTH must be at least 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Controller: CLEAR walks clr_addr over the whole array, READY serves users
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] clr_addr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RESET_STATE;
      clr_addr  <= '0;
      init_busy <= (CLEAR_ON_RESET != 0);
    end else begin
      state     <= state_nxt;
      clr_addr  <= clr_addr_nxt;
      init_busy <= (state_nxt == ST_CLEAR);
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      ST_CLEAR: begin
        clr_addr_nxt = clr_addr + 1'b1;
        // The edge that zeroes the last word is also the edge that leaves CLEAR.
        if (clr_addr == LAST_ADDR) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        state_nxt = ST_READY;
      end
      default: begin
        state_nxt = RESET_STATE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request qualification. reset gates the array write so that edges seen
  // while reset is held never touch the contents.
  // ---------------------------------------------------------------------------
  logic ready;
  logic clr_wr;
  logic user_wr;
  logic rd_fire;
  logic rdw_hit;

  assign ready   = (state == ST_READY);
  assign clr_wr  = !reset && (state == ST_CLEAR);
  assign user_wr = !reset && ready && write_en;
  assign rd_fire = !reset && ready && read_en;
  assign rdw_hit = user_wr && (waddr == raddr);

  // ---------------------------------------------------------------------------
  // Write port mux: clear sequence or user write
  // ---------------------------------------------------------------------------
  logic [NB-1:0]         mem_we_lanes;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we_lanes = '0;
    mem_waddr    = waddr;
    mem_wdata    = din;
    if (clr_wr) begin
      mem_we_lanes = '1;
      mem_waddr    = clr_addr;
      mem_wdata    = '0;
    end else if (user_wr) begin
      mem_we_lanes = byte_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array: no reset, byte-lane write enables only, so it maps onto a
  // simple dual-port block RAM with byte writes.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_we_lanes[b]) begin
        mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path. The array read is naturally read-first (old word). For the
  // new-data mode the merge with din is done here, outside the array, so the
  // array itself stays a plain RAM.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_rword;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign mem_rword = mem[raddr];

  always_comb begin
    merged_word = mem_rword;
    for (int b = 0; b < NB; b++) begin
      if (byte_en[b]) begin
        merged_word[b*8 +: 8] = din[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem_rword;
    if ((RDW_MODE != 0) && rdw_hit) begin
      rd_word = merged_word;
    end
  end

  // First read stage: the RAM output register. Data only moves on a read so
  // dout holds its last value between reads.
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_data <= rd_word;
      end
    end
  end

  // Optional second stage adds exactly one edge of latency and keeps the
  // strobe aligned with its data.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign dout       = s2_data;
      assign dout_valid = s2_valid;
    end else begin : g_no_out_reg
      assign dout       = s1_data;
      assign dout_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_be
//
// Four instances share one stimulus stream:
//   inst0: RDW_MODE=0 OUT_REG=0 CLEAR_ON_RESET=1 (defaults)
//   inst1: RDW_MODE=1 OUT_REG=1 CLEAR_ON_RESET=1
//   inst2: RDW_MODE=0 OUT_REG=0 CLEAR_ON_RESET=0
//   inst3: RDW_MODE=1 OUT_REG=0 CLEAR_ON_RESET=1
// A behavioural model (word arrays, a clear countdown, a delay queue for the
// read latency) predicts every output after every edge.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_be;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam int NI    = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [DW-1:0] din;
  logic [NB-1:0] byte_en;
  logic          write_en;
  logic          read_en;

  logic [NI-1:0][DW-1:0] dout_w;
  logic [NI-1:0]         valid_w;
  logic [NI-1:0]         busy_w;

  dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .reset(reset), .waddr(waddr), .raddr(raddr), .din(din), .byte_en(byte_en),
    .write_en(write_en), .read_en(read_en), .dout(dout_w[0]), .dout_valid(valid_w[0]), .init_busy(busy_w[0]));
  dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset(reset), .waddr(waddr), .raddr(raddr), .din(din), .byte_en(byte_en),
    .write_en(write_en), .read_en(read_en), .dout(dout_w[1]), .dout_valid(valid_w[1]), .init_busy(busy_w[1]));
  dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .reset(reset), .waddr(waddr), .raddr(raddr), .din(din), .byte_en(byte_en),
    .write_en(write_en), .read_en(read_en), .dout(dout_w[2]), .dout_valid(valid_w[2]), .init_busy(busy_w[2]));
  dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u3 (
    .clk(clk), .reset(reset), .waddr(waddr), .raddr(raddr), .din(din), .byte_en(byte_en),
    .write_en(write_en), .read_en(read_en), .dout(dout_w[3]), .dout_valid(valid_w[3]), .init_busy(busy_w[3]));

  int cfg_rdw  [NI] = '{0, 1, 0, 1};
  int cfg_oreg [NI] = '{0, 1, 0, 0};
  int cfg_clr  [NI] = '{1, 1, 0, 1};

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            v;
    bit            k;
    logic [DW-1:0] d;
  } rd_t;

  logic [DW-1:0] m_mem      [NI][DEPTH];
  bit            m_known    [NI][DEPTH];
  int            m_busy_left[NI];
  rd_t           exp_q      [NI][$];
  logic [DW-1:0] e_dout     [NI];
  bit            e_valid    [NI];
  bit            e_known    [NI];
  bit            e_busy     [NI];

  int total = 0;
  int bad   = 0;

  // Asynchronous reset: outputs drop at once, clear (if any) restarts from 0.
  task automatic model_reset();
    rd_t idle;
    idle = '{v: 1'b0, k: 1'b1, d: '0};
    for (int i = 0; i < NI; i++) begin
      e_dout[i]      = '0;
      e_valid[i]     = 1'b0;
      e_known[i]     = 1'b1;
      m_busy_left[i] = (cfg_clr[i] != 0) ? DEPTH : 0;
      e_busy[i]      = (cfg_clr[i] != 0);
      exp_q[i].delete();
      for (int s = 0; s < cfg_oreg[i]; s++) exp_q[i].push_back(idle);
    end
  endtask

  // One rising edge: update the model with the inputs seen at that edge.
  task automatic step();
    rd_t           ent;
    rd_t           o;
    logic [DW-1:0] mrg;
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        ent = '{v: 1'b0, k: 1'b1, d: '0};
        if (m_busy_left[i] > 0) begin
          m_mem[i][DEPTH - m_busy_left[i]]   = '0;
          m_known[i][DEPTH - m_busy_left[i]] = 1'b1;
          m_busy_left[i]--;
        end else begin
          mrg = m_mem[i][waddr];
          for (int b = 0; b < NB; b++) if (byte_en[b]) mrg[b*8 +: 8] = din[b*8 +: 8];
          if (read_en) begin
            ent.v = 1'b1;
            if (write_en && waddr == raddr && cfg_rdw[i] != 0) begin
              ent.d = mrg;
              ent.k = m_known[i][raddr] || (byte_en == '1);
            end else begin
              ent.d = m_mem[i][raddr];
              ent.k = m_known[i][raddr];
            end
          end
          if (write_en) begin
            m_mem[i][waddr] = mrg;
            if (byte_en == '1) m_known[i][waddr] = 1'b1;
          end
        end
        exp_q[i].push_back(ent);
        o = exp_q[i].pop_front();
        e_valid[i] = o.v;
        if (o.v) begin
          e_dout[i]  = o.d;
          e_known[i] = o.k;
        end
        e_busy[i] = (m_busy_left[i] > 0);
      end
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    write_en = 1'b0;
    read_en  = 1'b0;
    waddr    = '0;
    raddr    = '0;
    din      = '0;
    byte_en  = '0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    write_en = 1'b1;
    waddr    = a;
    din      = d;
    byte_en  = be;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    read_en = 1'b1;
    raddr   = a;
  endtask

  task automatic pulse_reset_start();
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < NI; i++) for (int a = 0; a < DEPTH; a++) m_known[i][a] = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) begin
      total++;
      if (dout_w[i] !== '0 || valid_w[i] !== 1'b0 || busy_w[i] !== (cfg_clr[i] != 0)) begin
        bad++;
        $display("FAIL reset inst%0d: dout=%h valid=%b busy=%b, want 0/0/%0d", i, dout_w[i], valid_w[i], busy_w[i], cfg_clr[i]);
      end
    end
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Counts init_busy cycles after reset release, then reads back every word.
  task automatic test_clear_then_read(input string name, input bit check_zero);
    int cnt[NI];
    for (int i = 0; i < NI; i++) cnt[i] = 0;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < NI; i++) if (busy_w[i]) cnt[i]++;
      if (busy_w == '0) break;
      step();
      for (int i = 0; i < NI; i++) begin
        if (cfg_clr[i] != 0) begin
          total++;
          if (valid_w[i] !== 1'b0) begin
            bad++;
            $display("FAIL %s_clear_valid inst%0d: dout_valid=%b during clear, want 0", name, i, valid_w[i]);
          end
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      total++;
      if (cnt[i] != ((cfg_clr[i] != 0) ? DEPTH : 0)) begin
        bad++;
        $display("FAIL %s_busy_cycles inst%0d: %0d cycles, want %0d", name, i, cnt[i], (cfg_clr[i] != 0) ? DEPTH : 0);
      end
    end
    drive_idle();
    for (int a = 0; a < DEPTH + 1; a++) begin
      read_en = (a < DEPTH);
      raddr   = a[AW-1:0];
      step();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (valid_w[i] !== e_valid[i] || (e_known[i] && dout_w[i] !== e_dout[i]) ||
            (check_zero && cfg_clr[i] != 0 && valid_w[i] && dout_w[i] !== '0)) begin
          bad++;
          $display("FAIL %s_readback inst%0d step%0d: dout=%h valid=%b, want %h/%b", name, i, a, dout_w[i], valid_w[i], e_dout[i], e_valid[i]);
        end
      end
    end
    drive_idle();
    step();
  endtask

  // Issues a read of addr a (with optional simultaneous write already driven)
  // and checks the fixed constant per instance at that instance's latency.
  task automatic check_read_const(input string name, input logic [AW-1:0] a,
                                  input logic [DW-1:0] want_new, input logic [DW-1:0] want_old,
                                  input bit use_rdw);
    logic [DW-1:0] want;
    drive_read(a);
    for (int s = 0; s < 2; s++) begin
      step();
      drive_idle();
      for (int i = 0; i < NI; i++) begin
        want = (use_rdw && cfg_rdw[i] != 0) ? want_new : want_old;
        total++;
        if (valid_w[i] !== (cfg_oreg[i] == s) || (cfg_oreg[i] == s && dout_w[i] !== want)) begin
          bad++;
          $display("FAIL %s inst%0d edge%0d: dout=%h valid=%b, want %h/%b", name, i, s, dout_w[i], valid_w[i], want, cfg_oreg[i] == s);
        end
      end
    end
  endtask

  task automatic test_byte_merge();
    drive_idle();
    drive_write(5'd3, 32'hAABBCCDD, 4'b1111);
    step();
    drive_write(5'd3, 32'h11223344, 4'b0101);
    step();
    drive_idle();
    check_read_const("byte_merge", 5'd3, 32'hAA22CC44, 32'hAA22CC44, 1'b0);
    drive_write(5'd3, 32'h55667788, 4'b0000);
    step();
    drive_idle();
    check_read_const("byte_en_zero", 5'd3, 32'hAA22CC44, 32'hAA22CC44, 1'b0);
  endtask

  task automatic test_rdw();
    drive_idle();
    drive_write(5'd7, 32'h0, 4'b1111);
    step();
    drive_idle();
    drive_write(5'd7, 32'hFFFFFFFF, 4'b0011);
    check_read_const("rdw", 5'd7, 32'h0000FFFF, 32'h00000000, 1'b1);
    check_read_const("rdw_after", 5'd7, 32'h0000FFFF, 32'h0000FFFF, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat [NI];
    logic [5:0] want;
    for (int i = 0; i < NI; i++) pat[i] = '0;
    drive_idle();
    for (int s = 0; s < 6; s++) begin
      drive_idle();
      if (s < 4) drive_read(AW'($urandom_range(0, DEPTH - 1)));
      step();
      for (int i = 0; i < NI; i++) begin
        pat[i][s] = valid_w[i];
        total++;
        if (valid_w[i] !== e_valid[i] || (e_known[i] && dout_w[i] !== e_dout[i])) begin
          bad++;
          $display("FAIL b2b_data inst%0d step%0d: dout=%h valid=%b, want %h/%b", i, s, dout_w[i], valid_w[i], e_dout[i], e_valid[i]);
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      want = (cfg_oreg[i] != 0) ? 6'b011110 : 6'b001111;
      total++;
      if (pat[i] !== want) begin
        bad++;
        $display("FAIL b2b_strobes inst%0d: pattern=%b, want %b", i, pat[i], want);
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      write_en = 1'($urandom_range(0, 1));
      read_en  = 1'($urandom_range(0, 1));
      waddr    = AW'($urandom_range(0, (c % 3 == 0) ? 3 : DEPTH - 1));
      raddr    = AW'($urandom_range(0, (c % 3 == 0) ? 3 : DEPTH - 1));
      din      = $urandom;
      byte_en  = NB'($urandom_range(0, 15));
      if (c < DEPTH) drive_write(c[AW-1:0], $urandom, 4'b1111);
      step();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (valid_w[i] !== e_valid[i] || busy_w[i] !== e_busy[i] || (e_known[i] && dout_w[i] !== e_dout[i])) begin
          bad++;
          $display("FAIL random inst%0d cyc%0d: dout=%h valid=%b busy=%b, want %h/%b/%b", i, c, dout_w[i], valid_w[i], busy_w[i], e_dout[i], e_valid[i], e_busy[i]);
        end
      end
    end
    drive_idle();
    step();
    step();
  endtask

  task automatic test_reset_mid_clear();
    drive_idle();
    pulse_reset_start();
    step();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      drive_write(AW'($urandom_range(0, DEPTH - 1)), $urandom, NB'($urandom_range(1, 15)));
      drive_read(AW'($urandom_range(0, DEPTH - 1)));
      step();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (valid_w[i] !== e_valid[i] || busy_w[i] !== e_busy[i] || (e_known[i] && dout_w[i] !== e_dout[i])) begin
          bad++;
          $display("FAIL midclear_pre inst%0d cyc%0d: dout=%h valid=%b busy=%b, want %h/%b/%b", i, c, dout_w[i], valid_w[i], busy_w[i], e_dout[i], e_valid[i], e_busy[i]);
        end
      end
    end
    // Asynchronous assertion between edges
    #2;
    pulse_reset_start();
    for (int i = 0; i < NI; i++) begin
      total++;
      if (dout_w[i] !== '0 || valid_w[i] !== 1'b0 || busy_w[i] !== (cfg_clr[i] != 0)) begin
        bad++;
        $display("FAIL midclear_async inst%0d: dout=%h valid=%b busy=%b, want 0/0/%0d", i, dout_w[i], valid_w[i], busy_w[i], cfg_clr[i]);
      end
    end
    step();
    reset = 1'b0;
    #1;
    write_en = 1'b1;
    read_en  = 1'b1;
    waddr    = 5'd12;
    raddr    = 5'd12;
    din      = 32'hDEADBEEF;
    byte_en  = 4'b1111;
    test_clear_then_read("midclear", 1'b1);
  endtask

  task automatic test_no_clear();
    drive_idle();
    drive_write(5'd31, 32'h12345678, 4'b1111);
    step();
    drive_idle();
    pulse_reset_start();
    total++;
    if (busy_w[2] !== 1'b0) begin
      bad++;
      $display("FAIL noclear_busy_reset: init_busy=%b, want 0", busy_w[2]);
    end
    step();
    reset = 1'b0;
    #1;
    for (int c = 0; c < DEPTH + 1; c++) begin
      step();
      total++;
      if (busy_w[2] !== 1'b0) begin
        bad++;
        $display("FAIL noclear_busy cyc%0d: init_busy=%b, want 0", c, busy_w[2]);
      end
    end
    total++;
    if (busy_w !== '0) begin
      bad++;
      $display("FAIL noclear_all_ready: init_busy=%b, want 0000", busy_w);
    end
    // inst2 keeps its contents, the clearing instances return zero
    drive_read(5'd31);
    for (int s = 0; s < 2; s++) begin
      step();
      drive_idle();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (valid_w[i] !== (cfg_oreg[i] == s) ||
            (cfg_oreg[i] == s && dout_w[i] !== ((cfg_clr[i] != 0) ? 32'h0 : 32'h12345678))) begin
          bad++;
          $display("FAIL noclear_read inst%0d edge%0d: dout=%h valid=%b, want %h/%b", i, s, dout_w[i], valid_w[i],
                   (cfg_clr[i] != 0) ? 32'h0 : 32'h12345678, cfg_oreg[i] == s);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_clear_then_read("clear", 1'b0);
    test_byte_merge();
    test_rdw();
    test_back_to_back();
    test_random(300);
    test_reset_mid_clear();
    test_random(100);
    test_no_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
